// File: rtl/pkt_fifo_if.sv
// Host-side bus bundle for pkt_fifo: data/length strobes and status outputs.
// Latency: none, wires only.
// Backpressure: none on this bundle; the host watches full/empty/count itself.
// Ports (master = host, slave = FIFO):
//   wr_en/wr_data, rd_en/rd_data, len_wr_en/len_in, len_rd_en/len_out, err_clr,
//   count, empty, full, pkt_full, read_complete, overflow, underflow.
interface pkt_fifo_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int DEPTH  = 128
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              len_wr_en;
    logic [LEN_W-1:0]  len_in;
    logic              len_rd_en;
    logic [LEN_W-1:0]  len_out;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              pkt_full;
    logic              read_complete;
    logic              overflow;
    logic              underflow;
    logic              err_clr;

    modport master (
        output wr_en, wr_data, rd_en, len_wr_en, len_in, len_rd_en, err_clr,
        input  rd_data, len_out, count, empty, full, pkt_full, read_complete,
               overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, len_wr_en, len_in, len_rd_en, err_clr,
        output rd_data, len_out, count, empty, full, pkt_full, read_complete,
               overflow, underflow
    );
endinterface

// File: rtl/pkt_fifo.sv
// Purpose: single length-tagged packet FIFO between host registers and PHY datapath.
// Latency: a pushed word is visible on rd_data (show-ahead) the cycle after the write edge.
// Backpressure: none; writes while full and pops while empty are dropped (flagged if enabled).
// Ports: clk, reset_n (async active-low), bus (pkt_fifo_if.slave, see interface file).
// Optional sticky overflow/underflow flags: define PKT_FIFO_ERR_EN.
module pkt_fifo #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 128,
    parameter int                LEN_W     = 8,
    parameter int                EDGE_MODE = 1,
    parameter logic [DATA_W-1:0] IDLE_VAL  = DATA_W'(8'h1F)
) (
    input  logic       clk,
    input  logic       reset_n,
    pkt_fifo_if.slave  bus
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam bit                EDGE     = (EDGE_MODE != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] wr_tot_q, wr_tot_d;
    logic [LEN_W-1:0] rd_tot_q, rd_tot_d;
    logic             wr_en_q, rd_en_q;

    logic empty, full;
    logic wr_fire, rd_fire;
    logic do_wr, do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Edge mode: write on the rising strobe, pop on the falling one so the host
    // has already sampled the head word before it advances.
    assign wr_fire = EDGE ? (bus.wr_en & ~wr_en_q) : bus.wr_en;
    assign rd_fire = EDGE ? (rd_en_q & ~bus.rd_en) : bus.rd_en;

    // A length load flushes the FIFO and swallows any concurrent strobe.
    assign do_wr = wr_fire & ~full  & ~bus.len_wr_en;
    assign do_rd = rd_fire & ~empty & ~bus.len_wr_en;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        len_d    = len_q;
        wr_tot_d = wr_tot_q;
        rd_tot_d = rd_tot_q;
        if (bus.len_wr_en) begin
            len_d    = bus.len_in;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            wr_tot_d = '0;
            rd_tot_d = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
                if (wr_tot_q != '1) wr_tot_d = wr_tot_q + LEN_W'(1);
            end
            if (do_rd) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
                if (rd_tot_q != '1) rd_tot_d = rd_tot_q + LEN_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            len_q    <= '0;
            wr_tot_q <= '0;
            rd_tot_q <= '0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            len_q    <= len_d;
            wr_tot_q <= wr_tot_d;
            rd_tot_q <= rd_tot_d;
            // Strobe history tracks the pins every cycle, even during a flush.
            wr_en_q  <= bus.wr_en;
            rd_en_q  <= bus.rd_en;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= bus.wr_data;
    end

`ifdef PKT_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;
    logic ovf_set, udf_set;

    // A set event beats a simultaneous clear; flush cycles leave flags alone.
    assign ovf_set = wr_fire & full  & ~bus.len_wr_en;
    assign udf_set = rd_fire & empty & ~bus.len_wr_en;

    always_comb begin
        ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
        udf_d = udf_set | (udf_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif

    assign bus.rd_data       = bus.rd_en ? (empty ? '0 : mem_q[rd_ptr_q]) : IDLE_VAL;
    assign bus.len_out       = bus.len_rd_en ? len_q : '0;
    assign bus.count         = count_q;
    assign bus.empty         = empty;
    assign bus.full          = full;
    assign bus.pkt_full      = (wr_tot_q >= len_q) & (wr_tot_q != '0) & ~bus.wr_en;
    assign bus.read_complete = (rd_tot_q >= len_q) & ~bus.rd_en;
endmodule

// File: tb/tb_pkt_fifo.sv
// Bench for pkt_fifo: edge-mode 128-deep instance (A) and level-mode 4-deep instance (B).
// Inputs change one time unit after the falling edge; outputs are checked there too.
// Expected data comes from a queue filled as words are written.
module tb_pkt_fifo;
`ifdef PKT_FIFO_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pkt_fifo_if #(.DATA_W(8), .LEN_W(8), .DEPTH(128)) ifa ();
    pkt_fifo_if #(.DATA_W(8), .LEN_W(8), .DEPTH(4))   ifb ();

    pkt_fifo #(.DATA_W(8), .DEPTH(128), .LEN_W(8), .EDGE_MODE(1)) u_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa));
    pkt_fifo #(.DATA_W(8), .DEPTH(4), .LEN_W(8), .EDGE_MODE(0)) u_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb));

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    typedef struct {
        bit         wr;
        logic [7:0] wdat;
        bit         rd;
        bit         clr;
        int         cnt;
        bit         ovf;
        bit         udf;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_wr_a(input logic [7:0] d);
        ifa.wr_en = 1'b1;
        ifa.wr_data = d;
        sb.push_back(d);
        step();
        ifa.wr_en = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1);
    end

    initial begin
        int mcount;
        logic [7:0] exp_d;
        ifa.wr_en = 0; ifa.wr_data = 0; ifa.rd_en = 0; ifa.len_wr_en = 0;
        ifa.len_in = 0; ifa.len_rd_en = 0; ifa.err_clr = 0;
        ifb.wr_en = 0; ifb.wr_data = 0; ifb.rd_en = 0; ifb.len_wr_en = 0;
        ifb.len_in = 0; ifb.len_rd_en = 0; ifb.err_clr = 0;

        // Level-mode vector table.
        for (int k = 0; k < 5; k++)
            tbl[k] = '{1'b1, 8'(8'h10 + k), 1'b0, 1'b0, (k + 1 > 4) ? 4 : k + 1, (k == 4), 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 3, 1'b0, 1'b0};
        for (int k = 6; k < 16; k++)
            tbl[k] = '{1'b1, 8'(8'h20 + k), 1'b1, 1'b0, 3, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1};

        // Reset values.
        #3;
        chk("rst_rd_data", ifa.rd_data, 8'h1F);
        chk("rst_len_out", ifa.len_out, 0);
        chk("rst_count", ifa.count, 0);
        chk("rst_empty", ifa.empty, 1);
        chk("rst_full", ifa.full, 0);
        chk("rst_pkt_full", ifa.pkt_full, 0);
        chk("rst_read_complete", ifa.read_complete, 1);
        chk("rst_overflow", ifa.overflow, 0);
        chk("rst_underflow", ifa.underflow, 0);
        step();
        reset_n = 1'b1;
        step();

        // Edge mode: load length 4, write four words.
        ifa.len_wr_en = 1'b1; ifa.len_in = 8'd4;
        step();
        ifa.len_wr_en = 1'b0; ifa.len_rd_en = 1'b1;
        #1;
        chk("a_len_out", ifa.len_out, 4);
        ifa.len_rd_en = 1'b0;
        step();
        for (int i = 0; i < 4; i++) pulse_wr_a(8'(8'hA0 + i));
        chk("a_count4", ifa.count, 4);
        chk("a_pkt_full", ifa.pkt_full, 1);
        chk("a_rc_before_read", ifa.read_complete, 0);

        // Four read pulses; head sampled while rd_en is high, pop on the fall.
        for (int i = 0; i < 4; i++) begin
            ifa.rd_en = 1'b1;
            #1;
            exp_d = sb.pop_front();
            chk($sformatf("a_rd_data%0d", i), ifa.rd_data, exp_d);
            step();
            ifa.rd_en = 1'b0;
            step();
        end
        chk("a_empty_after_read", ifa.empty, 1);
        chk("a_read_complete", ifa.read_complete, 1);
        chk("a_idle_val", ifa.rd_data, 8'h1F);

        // Pop on empty.
        ifa.rd_en = 1'b1;
        #1;
        chk("a_rd_data_empty", ifa.rd_data, 0);
        step();
        ifa.rd_en = 1'b0;
        step();
        chk("a_underflow", ifa.underflow, ERR);
        chk("a_count_after_udf", ifa.count, 0);
        ifa.err_clr = 1'b1;
        step();
        ifa.err_clr = 1'b0;
        chk("a_underflow_clr", ifa.underflow, 0);

        // Level mode, DEPTH=4: overflow, push+pop across wrap, drain, underflow.
        mcount = 0;
        for (int r = 0; r < 20; r++) begin
            ifb.wr_en = tbl[r].wr; ifb.wr_data = tbl[r].wdat;
            ifb.rd_en = tbl[r].rd; ifb.err_clr = tbl[r].clr;
            #1;
            if (tbl[r].rd) begin
                if (mcount > 0) begin
                    exp_d = sb.pop_front();
                    chk($sformatf("b_head_r%0d", r), ifb.rd_data, exp_d);
                end else begin
                    chk($sformatf("b_head_empty_r%0d", r), ifb.rd_data, 0);
                end
            end
            if (tbl[r].wr && mcount < 4) sb.push_back(tbl[r].wdat);
            mcount = mcount + ((tbl[r].wr && mcount < 4) ? 1 : 0)
                            - ((tbl[r].rd && mcount > 0) ? 1 : 0);
            step();
            chk($sformatf("b_count_r%0d", r), ifb.count, tbl[r].cnt);
            chk($sformatf("b_full_r%0d", r), ifb.full, (tbl[r].cnt == 4));
            chk($sformatf("b_empty_r%0d", r), ifb.empty, (tbl[r].cnt == 0));
            chk($sformatf("b_ovf_r%0d", r), ifb.overflow, tbl[r].ovf & ERR);
            chk($sformatf("b_udf_r%0d", r), ifb.underflow, tbl[r].udf & ERR);
        end
        ifb.wr_en = 1'b0; ifb.rd_en = 1'b0; ifb.err_clr = 1'b0;
        #1;
        chk("b_pkt_full_len0", ifb.pkt_full, 1);
        chk("b_read_complete_len0", ifb.read_complete, 1);
        chk("b_idle_val", ifb.rd_data, 8'h1F);
        step();

        // Length load in the middle of a burst discards the concurrent write.
        sb.delete();
        pulse_wr_a(8'h51);
        pulse_wr_a(8'h52);
        chk("a_count_burst", ifa.count, 2);
        ifa.wr_en = 1'b1; ifa.wr_data = 8'h53;
        ifa.len_wr_en = 1'b1; ifa.len_in = 8'd2;
        step();
        sb.delete();
        ifa.len_wr_en = 1'b0;
        ifa.rd_en = 1'b1; ifa.len_rd_en = 1'b1;
        #1;
        chk("a_flush_count", ifa.count, 0);
        chk("a_flush_empty", ifa.empty, 1);
        chk("a_flush_head", ifa.rd_data, 0);
        chk("a_flush_len", ifa.len_out, 2);
        ifa.wr_en = 1'b0;
        step();
        chk("a_flush_still_empty", ifa.count, 0);
        ifa.rd_en = 1'b0;
        step();

        // Asynchronous reset mid-packet.
        pulse_wr_a(8'h61);
        chk("a_count_pre_rst", ifa.count, 1);
        ifa.rd_en = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("a_async_count", ifa.count, 0);
        chk("a_async_empty", ifa.empty, 1);
        chk("a_async_head", ifa.rd_data, 0);
        chk("a_async_len", ifa.len_out, 0);
        chk("a_async_udf", ifa.underflow, 0);
        step();
        reset_n = 1'b1;
        step();
        chk("a_post_rst_count", ifa.count, 0);
        chk("a_post_rst_head", ifa.rd_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
